// File: rtl/ysyx_23060077_axi_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060077_axi_arbiter_pkg
// Shared definitions for the IFU/LSU -> AXI bridge request arbiter:
//   - read FSM state encoding (ARB_R_IDLE / ARB_R_IFU / ARB_R_LSU)
//   - write FSM state encoding (ARB_W_IDLE / ARB_W_BUSY)
//   - master-select constants used by the round-robin picker
// No ports (package).
// ---------------------------------------------------------------------------
package ysyx_23060077_axi_arbiter_pkg;

   localparam int ARB_R_STATE_W = 2;
   localparam int ARB_W_STATE_W = 1;

   typedef enum logic [ARB_R_STATE_W-1:0] {
      ARB_R_IDLE = 2'd0,
      ARB_R_IFU  = 2'd1,
      ARB_R_LSU  = 2'd2
   } arb_r_state_e;

   typedef enum logic [ARB_W_STATE_W-1:0] {
      ARB_W_IDLE = 1'b0,
      ARB_W_BUSY = 1'b1
   } arb_w_state_e;

   // Bit positions in the picker request vector double as grant codes.
   localparam logic ARB_SEL_IFU = 1'b0;
   localparam logic ARB_SEL_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060077_arb_rr2.sv
// ---------------------------------------------------------------------------
// ysyx_23060077_arb_rr2
// Two-way round-robin picker. A single request wins outright; on a tie the
// master that was NOT granted last wins. last_grant only moves when the
// owner commits the pick (update & grant_valid).
// Ports:
//   aclk, areset_n   clock, async active-high reset (last_grant -> LSU)
//   req[1:0]         requests, indexed by ARB_SEL_IFU / ARB_SEL_LSU
//   update           commit the current pick into last_grant
//   grant            picked master (ARB_SEL_*), meaningful when grant_valid
//   grant_valid      at least one request present
// ---------------------------------------------------------------------------
module ysyx_23060077_arb_rr2
   import ysyx_23060077_axi_arbiter_pkg::*;
(
   input  logic       aclk,
   input  logic       areset_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic       grant,
   output logic       grant_valid
);

   logic last_grant;

   // Reset to LSU so that the IFU wins the first tie.
   always_ff @(posedge aclk or posedge areset_n) begin
      if (areset_n) begin
         last_grant <= ARB_SEL_LSU;
      end else if (update && grant_valid) begin
         last_grant <= grant;
      end
   end

   always_comb begin
      grant_valid = |req;
      grant       = ARB_SEL_IFU;
      if (&req) begin
         grant = ~last_grant;
      end else if (req[ARB_SEL_LSU]) begin
         grant = ARB_SEL_LSU;
      end
   end

endmodule

// File: rtl/ysyx_23060077_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060077_axi_arbiter
// Sits in front of the AXI master bridge. Reads from IFU and LSU are
// arbitrated round-robin; LSU stores go through a two-state write FSM.
// Request attributes are registered at grant so the bridge sees stable
// addr/size/len for a whole transaction. An LSU read is held back while an
// LSU write is pending or in flight (read-after-write ordering); IFU reads
// may overlap an LSU write.
//
// Handshake: a requester raises *_valid_i with stable attributes and holds
// it until it sees its *_last_o. Each cycle with *_ready_o = 1 carries one
// beat (read data to the master, or write data accepted from the LSU).
// cpu_*_valid_o is a pure decode of registered state, so there is no
// combinational path from any *_valid_i to the bridge request.
//
// Ports:
//   aclk, areset_n                clock, async active-high reset
//   ifu_r_* / lsu_r_*             read requests and routed read beats
//   lsu_w_*                       write request, data, beat accept, response
//   cpu_r_* / cpu_w_*             request interface to the AXI bridge
//   dbg_r_state / dbg_w_state     current FSM states (observation only)
// ---------------------------------------------------------------------------
module ysyx_23060077_axi_arbiter
   import ysyx_23060077_axi_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int SIZE_WIDTH = 3,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  aclk,
   input  logic                  areset_n,
   // IFU read
   input  logic                  ifu_r_valid_i,
   input  logic [ADDR_WIDTH-1:0] ifu_r_addr_i,
   input  logic [SIZE_WIDTH-1:0] ifu_r_size_i,
   input  logic [LEN_WIDTH-1:0]  ifu_r_len_i,
   output logic                  ifu_r_ready_o,
   output logic [DATA_WIDTH-1:0] ifu_r_data_o,
   output logic                  ifu_r_last_o,
   // LSU read
   input  logic                  lsu_r_valid_i,
   input  logic [ADDR_WIDTH-1:0] lsu_r_addr_i,
   input  logic [SIZE_WIDTH-1:0] lsu_r_size_i,
   input  logic [LEN_WIDTH-1:0]  lsu_r_len_i,
   output logic                  lsu_r_ready_o,
   output logic [DATA_WIDTH-1:0] lsu_r_data_o,
   output logic                  lsu_r_last_o,
   // LSU write
   input  logic                  lsu_w_valid_i,
   input  logic [ADDR_WIDTH-1:0] lsu_w_addr_i,
   input  logic [SIZE_WIDTH-1:0] lsu_w_size_i,
   input  logic [LEN_WIDTH-1:0]  lsu_w_len_i,
   input  logic [DATA_WIDTH-1:0] lsu_w_data_i,
   output logic                  lsu_w_ready_o,
   output logic                  lsu_w_last_o,
   // Bridge read
   output logic                  cpu_r_valid_o,
   output logic [ADDR_WIDTH-1:0] cpu_r_addr_o,
   output logic [SIZE_WIDTH-1:0] cpu_r_size_o,
   output logic [LEN_WIDTH-1:0]  cpu_r_len_o,
   input  logic                  cpu_r_ready_i,
   input  logic [DATA_WIDTH-1:0] cpu_r_data_i,
   input  logic                  cpu_r_last_i,
   // Bridge write
   output logic                  cpu_w_valid_o,
   output logic [ADDR_WIDTH-1:0] cpu_w_addr_o,
   output logic [SIZE_WIDTH-1:0] cpu_w_size_o,
   output logic [LEN_WIDTH-1:0]  cpu_w_len_o,
   output logic [DATA_WIDTH-1:0] cpu_w_data_o,
   input  logic                  cpu_w_ready_i,
   input  logic                  cpu_w_last_i,
   // Observation
   output arb_r_state_e          dbg_r_state,
   output arb_w_state_e          dbg_w_state
);

   arb_r_state_e r_state, r_state_d;
   arb_w_state_e w_state, w_state_d;

   logic                  r_latch, w_latch;
   logic [ADDR_WIDTH-1:0] r_addr_q, w_addr_q;
   logic [SIZE_WIDTH-1:0] r_size_q, w_size_q;
   logic [LEN_WIDTH-1:0]  r_len_q,  w_len_q;

   logic       lsu_elig;
   logic       rr_grant, rr_grant_valid;
   logic       r_done;

   // LSU read waits while its own store is requested or still in flight.
   assign lsu_elig = lsu_r_valid_i & (w_state == ARB_W_IDLE) & ~lsu_w_valid_i;
   assign r_done   = cpu_r_ready_i & cpu_r_last_i;

   ysyx_23060077_arb_rr2 u_rr2 (
      .aclk        (aclk),
      .areset_n    (areset_n),
      .req         ({lsu_elig, ifu_r_valid_i}),
      .update      (r_state == ARB_R_IDLE),
      .grant       (rr_grant),
      .grant_valid (rr_grant_valid)
   );

   always_ff @(posedge aclk or posedge areset_n) begin
      if (areset_n) begin
         r_state  <= ARB_R_IDLE;
         w_state  <= ARB_W_IDLE;
         r_addr_q <= '0;
         r_size_q <= '0;
         r_len_q  <= '0;
         w_addr_q <= '0;
         w_size_q <= '0;
         w_len_q  <= '0;
      end else begin
         r_state <= r_state_d;
         w_state <= w_state_d;
         if (r_latch) begin
            if (rr_grant == ARB_SEL_LSU) begin
               r_addr_q <= lsu_r_addr_i;
               r_size_q <= lsu_r_size_i;
               r_len_q  <= lsu_r_len_i;
            end else begin
               r_addr_q <= ifu_r_addr_i;
               r_size_q <= ifu_r_size_i;
               r_len_q  <= ifu_r_len_i;
            end
         end
         if (w_latch) begin
            w_addr_q <= lsu_w_addr_i;
            w_size_q <= lsu_w_size_i;
            w_len_q  <= lsu_w_len_i;
         end
      end
   end

   // Read FSM: grant only from IDLE, so requester changes mid-burst are ignored.
   always_comb begin
      r_state_d     = r_state;
      r_latch       = 1'b0;
      ifu_r_ready_o = 1'b0;
      ifu_r_last_o  = 1'b0;
      lsu_r_ready_o = 1'b0;
      lsu_r_last_o  = 1'b0;
      case (r_state)
         ARB_R_IDLE: begin
            if (rr_grant_valid) begin
               r_latch   = 1'b1;
               r_state_d = (rr_grant == ARB_SEL_LSU) ? ARB_R_LSU : ARB_R_IFU;
            end
         end
         ARB_R_IFU: begin
            ifu_r_ready_o = cpu_r_ready_i;
            ifu_r_last_o  = r_done;
            if (r_done) r_state_d = ARB_R_IDLE;
         end
         ARB_R_LSU: begin
            lsu_r_ready_o = cpu_r_ready_i;
            lsu_r_last_o  = r_done;
            if (r_done) r_state_d = ARB_R_IDLE;
         end
         default: r_state_d = ARB_R_IDLE;
      endcase
   end

   // Write FSM
   always_comb begin
      w_state_d     = w_state;
      w_latch       = 1'b0;
      lsu_w_ready_o = 1'b0;
      lsu_w_last_o  = 1'b0;
      case (w_state)
         ARB_W_IDLE: begin
            if (lsu_w_valid_i) begin
               w_latch   = 1'b1;
               w_state_d = ARB_W_BUSY;
            end
         end
         ARB_W_BUSY: begin
            lsu_w_ready_o = cpu_w_ready_i;
            lsu_w_last_o  = cpu_w_last_i;
            if (cpu_w_last_i) w_state_d = ARB_W_IDLE;
         end
         default: w_state_d = ARB_W_IDLE;
      endcase
   end

   assign cpu_r_valid_o = (r_state != ARB_R_IDLE);
   assign cpu_r_addr_o  = r_addr_q;
   assign cpu_r_size_o  = r_size_q;
   assign cpu_r_len_o   = r_len_q;
   assign ifu_r_data_o  = cpu_r_data_i;
   assign lsu_r_data_o  = cpu_r_data_i;

   assign cpu_w_valid_o = (w_state == ARB_W_BUSY);
   assign cpu_w_addr_o  = w_addr_q;
   assign cpu_w_size_o  = w_size_q;
   assign cpu_w_len_o   = w_len_q;
   assign cpu_w_data_o  = lsu_w_data_i;

   assign dbg_r_state = r_state;
   assign dbg_w_state = w_state;

endmodule
